// File: rtl/spi_count_pkg.sv
// spi_count_pkg: opcodes, FSM encoding and BCD helper for spi_count_slave
package spi_count_pkg;
    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_CLEAR  = 8'h02;
    localparam logic [7:0] OP_CLRERR = 8'h03;
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        to_bcd = {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction
endpackage

// File: rtl/spi_count_slave_if.sv
// spi_count_slave_if: SPI bus between master and spi_count_slave
interface spi_count_slave_if;
    logic ss, sclk, mosi, miso;
    modport master (output ss, sclk, mosi, input miso);
    modport slave (input ss, sclk, mosi, output miso);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses in the clk domain
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    always_comb begin
        sync_d = STAGES'({sync_q, d});
        prev_d = q;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sync_q <= {STAGES{INIT}};
            prev_q <= INIT;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;
endmodule

// File: rtl/spi_count_slave.sv
// spi_count_slave: SPI mode-0 slave holding a 6-bit count value with BCD outputs
// and a sticky frame error flag, all sampled in the clk domain.
module spi_count_slave import spi_count_pkg::*; #(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_count_slave_if.slave         spi,
    output logic [5:0]               value,
    output logic [3:0]               tens,
    output logic [3:0]               ones,
    output logic                     frame_valid,
    output logic                     frame_err
);
    state_t state_q, state_d;
    logic [4:0] bits_q, bits_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d, tx_q, tx_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic [5:0] value_q, value_d;
    logic err_q, err_d, valid_q, valid_d;
    logic ss_lvl, ss_rise, ss_fall_unused, sclk_lvl_unused, sclk_rise, sclk_fall;
    logic [7:0] op;
    logic good;
    logic [1:0] data_hi_unused;
    logic [FRAME_BITS+15:0] tx_ext;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
        .clk(clk), .rst(rst), .d(spi.ss), .q(ss_lvl), .rise(ss_rise), .fall(ss_fall_unused));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(spi.sclk), .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));

    assign op             = shreg_q[FRAME_BITS-1 -: 8];
    assign data_hi_unused = shreg_q[FRAME_BITS-9 -: 2];
    assign good   = bits_q == 5'(FRAME_BITS) && (op == OP_LOAD || op == OP_CLEAR || op == OP_CLRERR);
    assign tx_ext = {2'b00, value_q, 7'b0, err_q, FRAME_BITS'(0)};

    // The frame is judged on the ss rise so frame_valid and value land together in CHECK
    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        mosi_d  = SYNC_STAGES'({mosi_q, spi.mosi});
        value_d = value_q;
        err_d   = err_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: if (!ss_lvl) begin
                state_d = SHIFT;
                bits_d  = '0;
                shreg_d = '0;
                tx_d    = tx_ext[FRAME_BITS+15 -: FRAME_BITS];
            end
            SHIFT: if (ss_rise) begin
                state_d = CHECK;
                valid_d = good;
                err_d   = good ? (op == OP_CLRERR ? 1'b0 : err_q) : 1'b1;
                value_d = !good ? value_q : op == OP_LOAD ? shreg_q[FRAME_BITS-11 -: 6]
                        : op == OP_CLEAR ? 6'd0 : value_q;
            end else begin
                if (sclk_rise) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], mosi_q[SYNC_STAGES-1]};
                    bits_d  = bits_q == 5'd31 ? bits_q : bits_q + 5'd1;
                end
                if (sclk_fall) tx_d = tx_q << 1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            bits_q  <= '0;
            shreg_q <= '0;
            tx_q    <= '0;
            mosi_q  <= '0;
            value_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            mosi_q  <= mosi_d;
            value_q <= value_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end

    assign value         = value_q;
    assign {tens, ones}  = to_bcd(value_q);
    assign frame_valid   = valid_q;
    assign frame_err     = err_q;
    assign spi.miso      = state_q == SHIFT && tx_q[FRAME_BITS-1];
endmodule

// File: doc/spi_count_slave.md
SPI_COUNT_SLAVE -- requirements
Module: spi_count_slave

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 16, meaning bits per SPI frame (8 command + 8 data).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on ss, sclk and mosi.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 ss  input  1  SPI slave select, active-low, asynchronous to clk.
REQ-006 sclk  input  1  SPI clock, mode 0 (idle low), asynchronous to clk, at most clk/4.
REQ-007 mosi  input  1  serial data from master, MSB first.
REQ-008 miso  output  1  serial data to master, MSB first.
REQ-009 value  output  6  last loaded count value (0..63).
REQ-010 tens  output  4  BCD tens digit of value.
REQ-011 ones  output  4  BCD ones digit of value.
REQ-012 frame_valid  output  1  one-cycle pulse when a well-formed frame is accepted.
REQ-013 frame_err  output  1  sticky error flag: short frame, long frame or bad opcode.

Function
REQ-014 ss, sclk and mosi SHALL pass through SYNC_STAGES flops; sclk edges and the ss rising edge SHALL be detected in the clk domain.
REQ-015 FSM states: IDLE, SHIFT, CHECK; IDLE->SHIFT on synchronized ss low, SHIFT->CHECK on synchronized ss rising edge, CHECK->IDLE unconditionally after one cycle.
REQ-016 In SHIFT, each synchronized sclk rising edge SHALL shift mosi into a FRAME_BITS shift register and increment a 5-bit bit counter, saturating at 31.
REQ-017 In SHIFT, each synchronized sclk falling edge SHALL advance miso to the next bit of the transmit word.
REQ-018 The transmit word SHALL be {2'b00, value, 7'b0, frame_err}, loaded on IDLE->SHIFT, with its MSB driven on miso from that same cycle.
REQ-019 In CHECK with bit count == FRAME_BITS: opcode 8'h01 SHALL set value = data[5:0] (data[7:6] ignored); 8'h02 SHALL set value = 0; 8'h03 SHALL clear frame_err; each SHALL pulse frame_valid in the CHECK cycle.
REQ-020 In CHECK, bit count < FRAME_BITS, bit count > FRAME_BITS, or any other opcode SHALL discard the frame, set frame_err, and leave frame_valid low.
REQ-021 tens/ones SHALL be combinational from value (value 40 -> tens 4, ones 0; 63 -> 6, 3).
REQ-022 frame_valid and value update SHALL occur SYNC_STAGES+1 clk cycles after the raw ss rising edge.
REQ-023 miso SHALL be 0 in IDLE.
REQ-024 An sclk edge coinciding with the synchronized ss rising edge SHALL be ignored.
REQ-025 An opcode 8'h03 frame that is otherwise valid SHALL clear frame_err even if frame_err was set earlier; a malformed frame in the same CHECK SHALL take priority and set it.

Reset
REQ-026 On rst low: state IDLE, value 0, tens 0, ones 0, frame_valid 0, frame_err 0, miso 0, shift register 0, bit counter 0, synchronizers set to idle levels (ss 1, sclk 0, mosi 0).
REQ-027 rst asserted mid-frame SHALL abort the frame without updating value; after release, the module SHALL wait in IDLE for the next ss falling edge.

Structure
REQ-028 Package spi_count_pkg SHALL hold the opcode constants (OP_LOAD 8'h01, OP_CLEAR 8'h02, OP_CLRERR 8'h03) and the FSM state encoding.
REQ-029 One sub-module spi_sync_edge SHALL implement an SYNC_STAGES-deep synchronizer with rise/fall pulse outputs, instantiated for ss and sclk.

Verification
REQ-030 Reset, then frame 16'h0128 -> frame_valid pulse once, value 40, tens 4, ones 0, frame_err 0.
REQ-031 After value 40, frame 16'h0200 -> value 0; miso during that frame shows 8'h28 in the first 8 bits.
REQ-032 Frame of 12 bits, then ss high -> frame_err 1, value unchanged, no frame_valid.
REQ-033 Opcode 8'h7F frame -> frame_err 1; then 16'h0300 -> frame_err 0, frame_valid pulse.
REQ-034 rst asserted after 8 bits of 16'h013F -> value 0; next full 16'h013F frame -> value 63, tens 6, ones 3.
REQ-035 18-bit frame -> frame_err 1, value unchanged; sclk at clk/4 with maximal jitter -> no lost or extra bits.
